// File: rtl/pattern_scan_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : pattern_scan_pkg
// Description : Shared definitions for the pattern scan run controller:
//               default widths and the run-state encoding.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
package pattern_scan_pkg;

  localparam int PSC_PAT_W = 4;  // pattern length in bits
  localparam int PSC_CNT_W = 3;  // match counter / threshold width
  localparam int PSC_WIN_W = 8;  // bit counter / window width

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_SCAN   = 2'b01,
    ST_REPORT = 2'b10
  } state_e;

endpackage : pattern_scan_pkg
`default_nettype wire

// File: rtl/pattern_shift_match.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : pattern_shift_match
// Description : Serial history shifter with fill tracking and a combinational
//               pattern comparator. The history keeps the PAT_W-1 most recent
//               accepted bits; together with the incoming bit they form the
//               PAT_W-bit candidate compared against the pattern.
// Ports       : clk_i      - clock
//               rst_i      - synchronous active-high reset
//               clr_i      - clear history and fill (start of run)
//               shift_en_i - accept x_i this cycle
//               x_i        - serial data bit
//               pat_i      - pattern to match, MSB is the oldest bit
//               hit_o      - combinational: accepting x_i completes a match
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module pattern_shift_match
  import pattern_scan_pkg::*;
#(
  parameter int PAT_W = PSC_PAT_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             shift_en_i,
  input  logic             x_i,
  input  logic [PAT_W-1:0] pat_i,
  output logic             hit_o
);

  localparam int FILL_W = $clog2(PAT_W + 1);
  localparam logic [FILL_W-1:0] C_FILL_MAX  = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] C_FILL_NEED = FILL_W'(PAT_W - 1);

  logic [PAT_W-2:0]  hist_q, hist_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0]  w_cand;

  // Candidate window: stored history followed by the bit being accepted now.
  assign w_cand = {hist_q, x_i};

  // Only PAT_W-1 prior bits are required before a full window exists.
  assign hit_o = shift_en_i && (fill_q >= C_FILL_NEED) && (w_cand == pat_i);

  always_comb begin
    hist_d = hist_q;
    fill_d = fill_q;
    if (clr_i) begin
      hist_d = '0;
      fill_d = '0;
    end else if (shift_en_i) begin
      hist_d = w_cand[PAT_W-2:0];
      if (fill_q != C_FILL_MAX) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_q <= '0;
      fill_q <= '0;
    end else begin
      hist_q <= hist_d;
      fill_q <= fill_d;
    end
  end

endmodule : pattern_shift_match
`default_nettype wire

// File: rtl/pattern_scan_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module      : pattern_scan_ctrl
// Description : Run controller for the serial pattern-detection datapath.
//               Latches pattern/threshold/window on START, counts overlapping
//               matches on qualified serial bits and finishes each run with a
//               one-cycle DONE pulse and a held PASS verdict.
// Ports       : clk_i, rst_i         - clock, synchronous active-high reset
//               start_i, abort_i     - run control
//               pat_i, thresh_i,
//               window_i             - run configuration (window 0 = no limit)
//               x_i, x_valid_i       - serial bit and qualifier
//               busy_o               - run in progress
//               match_o              - one-cycle pulse per match
//               done_o               - one-cycle pulse at run completion
//               pass_o               - verdict of last run
//               match_cnt_o          - saturating match count
//               bit_cnt_o            - saturating accepted bit count
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
module pattern_scan_ctrl
  import pattern_scan_pkg::*;
#(
  parameter int PAT_W = PSC_PAT_W,
  parameter int CNT_W = PSC_CNT_W,
  parameter int WIN_W = PSC_WIN_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic             abort_i,
  input  logic [PAT_W-1:0] pat_i,
  input  logic [CNT_W-1:0] thresh_i,
  input  logic [WIN_W-1:0] window_i,
  input  logic             x_i,
  input  logic             x_valid_i,
  output logic             busy_o,
  output logic             match_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [CNT_W-1:0] match_cnt_o,
  output logic [WIN_W-1:0] bit_cnt_o
);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] thresh_q, thresh_d;
  logic [WIN_W-1:0] window_q, window_d;
  logic [CNT_W-1:0] mcnt_q, mcnt_d;
  logic [WIN_W-1:0] bcnt_q, bcnt_d;
  logic             match_q, match_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             clr;
  logic             shift_en;
  logic             hit;

  // ABORT wins over bit acceptance, so the aborted cycle's bit never shifts.
  assign shift_en = (state_q == ST_SCAN) && x_valid_i && !abort_i;

  pattern_shift_match #(
    .PAT_W (PAT_W)
  ) u_shift_match (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .clr_i      (clr),
    .shift_en_i (shift_en),
    .x_i        (x_i),
    .pat_i      (pat_q),
    .hit_o      (hit)
  );

  always_comb begin
    state_d  = state_q;
    pat_d    = pat_q;
    thresh_d = thresh_q;
    window_d = window_q;
    mcnt_d   = mcnt_q;
    bcnt_d   = bcnt_q;
    match_d  = 1'b0;
    done_d   = 1'b0;
    pass_d   = pass_q;
    clr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          mcnt_d = '0;
          bcnt_d = '0;
          if (thresh_i != '0) begin
            pat_d    = pat_i;
            thresh_d = thresh_i;
            window_d = window_i;
            clr      = 1'b1;
            pass_d   = 1'b0;
            state_d  = ST_SCAN;
          end else begin
            // Zero threshold is trivially met: report a pass immediately.
            pass_d  = 1'b1;
            done_d  = 1'b1;
            state_d = ST_REPORT;
          end
        end
      end

      ST_SCAN: begin
        if (abort_i) begin
          pass_d  = 1'b0;
          state_d = ST_IDLE;
        end else begin
          if (x_valid_i) begin
            if (!(&bcnt_q)) begin
              bcnt_d = bcnt_q + WIN_W'(1);
            end
            if (hit) begin
              match_d = 1'b1;
              if (!(&mcnt_q)) begin
                mcnt_d = mcnt_q + CNT_W'(1);
              end
            end
          end
          // Exit tests use the updated counts; threshold outranks window.
          if (mcnt_d == thresh_q) begin
            pass_d  = 1'b1;
            done_d  = 1'b1;
            state_d = ST_REPORT;
          end else if ((window_q != '0) && (bcnt_d == window_q)) begin
            pass_d  = 1'b0;
            done_d  = 1'b1;
            state_d = ST_REPORT;
          end
        end
      end

      ST_REPORT: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      pat_q    <= '0;
      thresh_q <= '0;
      window_q <= '0;
      mcnt_q   <= '0;
      bcnt_q   <= '0;
      match_q  <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      pat_q    <= pat_d;
      thresh_q <= thresh_d;
      window_q <= window_d;
      mcnt_q   <= mcnt_d;
      bcnt_q   <= bcnt_d;
      match_q  <= match_d;
      done_q   <= done_d;
      pass_q   <= pass_d;
    end
  end

  assign busy_o      = (state_q == ST_SCAN);
  assign match_o     = match_q;
  assign done_o      = done_q;
  assign pass_o      = pass_q;
  assign match_cnt_o = mcnt_q;
  assign bit_cnt_o   = bcnt_q;

endmodule : pattern_scan_ctrl
`default_nettype wire
